// File: rtl/sb_timer_if.sv
// System-bus access port for the sb_timer peripheral.
// The master drives the chip select, strobe, address and write data.
// The slave returns read data and an access-fault flag in the same cycle.
interface sb_timer_if;
   logic        sb_ReadEnable;
   logic        sb_WriteEnable;
   logic [31:0] sb_Address;
   logic [31:0] sb_DataIn;
   logic [31:0] sb_DataOut;
   logic        sb_exception;

   modport master (
      output sb_ReadEnable,
      output sb_WriteEnable,
      output sb_Address,
      output sb_DataIn,
      input  sb_DataOut,
      input  sb_exception
   );

   modport slave (
      input  sb_ReadEnable,
      input  sb_WriteEnable,
      input  sb_Address,
      input  sb_DataIn,
      output sb_DataOut,
      output sb_exception
   );
endinterface

// File: rtl/sb_timer.sv
// sb_timer: NUM_TIMERS 32-bit down-counting timers on the system bus.
// Each timer has CTRL (EN, MODE, IM), PRESET and a read-only COUNT.
// The timers support one-shot and auto-reload modes.
// Each timer has a registered, maskable interrupt line.
// Read data and faults are combinational so the data-memory stage sees them
// in the access cycle.
module sb_timer #(
   parameter int NUM_TIMERS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   sb_timer_if.slave             sb,
   output logic [NUM_TIMERS-1:0] irq
);

   localparam int IDX_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_NONE   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   logic [1:0]            off_s;
   logic [IDX_W-1:0]      idx_s;
   logic                  exc_s;
   logic                  wr_ok_s;
   logic [NUM_TIMERS-1:0] hit_s;
   logic [31:0]           rdata_s;
   logic [3:0]            ctrl_q_s   [NUM_TIMERS];
   logic [31:0]           preset_q_s [NUM_TIMERS];
   logic [31:0]           count_q_s  [NUM_TIMERS];

   // Address bits outside the decoded word/timer field are intentionally ignored.
   logic unused_addr_s;
   assign unused_addr_s = ^{sb.sb_Address[31:4+IDX_W], sb.sb_Address[1:0]};

   // Decode the access: register offset, fault condition and addressed timer.
   always_comb begin
      off_s   = sb.sb_Address[3:2];
      idx_s   = sb.sb_Address[4 +: IDX_W];
      exc_s   = 1'b0;
      if (sb.sb_ReadEnable) begin
         if (off_s == OFF_NONE) begin
            exc_s = 1'b1;
         end else if (sb.sb_WriteEnable && (off_s == OFF_COUNT)) begin
            exc_s = 1'b1;
         end else begin
            exc_s = 1'b0;
         end
      end else begin
         exc_s = 1'b0;
      end
      wr_ok_s = sb.sb_ReadEnable && sb.sb_WriteEnable && !exc_s;
      for (int k = 0; k < NUM_TIMERS; k++) begin
         hit_s[k] = (idx_s == IDX_W'(k));
      end
   end

   // Read-data mux: the selected register, or zero when idle or faulting.
   always_comb begin
      rdata_s = 32'd0;
      if (sb.sb_ReadEnable && !exc_s) begin
         for (int k = 0; k < NUM_TIMERS; k++) begin
            if (hit_s[k]) begin
               case (off_s)
                  OFF_CTRL:   rdata_s = {28'd0, ctrl_q_s[k]};
                  OFF_PRESET: rdata_s = preset_q_s[k];
                  OFF_COUNT:  rdata_s = count_q_s[k];
                  default:    rdata_s = 32'd0;
               endcase
            end else begin
               rdata_s = rdata_s;
            end
         end
      end else begin
         rdata_s = 32'd0;
      end
   end

   assign sb.sb_DataOut   = rdata_s;
   assign sb.sb_exception = exc_s;

   for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
      logic [3:0]  ctrl_r;
      logic [31:0] preset_r;
      logic [31:0] count_r;
      state_t      state_r;
      logic        pending_r;
      logic        irq_r;
      logic        wr_ctrl_s;
      logic        wr_preset_s;
      logic        en_s;
      logic        auto_s;
      logic        pend_set_s;

      assign wr_ctrl_s   = wr_ok_s && hit_s[k] && (off_s == OFF_CTRL);
      assign wr_preset_s = wr_ok_s && hit_s[k] && (off_s == OFF_PRESET);
      assign en_s        = ctrl_r[0];
      // MODE 2 and 3 fall back to one-shot, so only MODE 1 reloads.
      assign auto_s      = (ctrl_r[2:1] == 2'd1);
      // The transition into INT is the only event that raises pending.
      assign pend_set_s  = (state_r == ST_CNT) && en_s && (count_r <= 32'd1);

      // Timer FSM with its registers, pending flag and registered interrupt.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            ctrl_r    <= 4'd0;
            preset_r  <= 32'd0;
            count_r   <= 32'd0;
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
            irq_r     <= 1'b0;
         end else begin
            irq_r <= pending_r && ctrl_r[3];

            // PRESET only reaches COUNT through LOAD, so a write mid-count
            // does not disturb the count in progress.
            if (wr_preset_s) begin
               preset_r <= sb.sb_DataIn;
            end

            case (state_r)
               ST_IDLE: begin
                  if (en_s) begin
                     state_r <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  count_r <= preset_r;
                  state_r <= ST_CNT;
               end
               ST_CNT: begin
                  if (!en_s) begin
                     state_r <= ST_IDLE;
                  end else if (count_r > 32'd1) begin
                     count_r <= count_r - 32'd1;
                  end else begin
                     count_r <= 32'd0;
                     state_r <= ST_INT;
                  end
               end
               ST_INT: begin
                  if (auto_s) begin
                     state_r <= ST_LOAD;
                  end else begin
                     ctrl_r[0] <= 1'b0;
                     state_r   <= ST_IDLE;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase

            // Placed after the FSM so a bus write overrides the EN clear in INT.
            if (wr_ctrl_s) begin
               ctrl_r <= sb.sb_DataIn[3:0];
            end

            // A set in the same cycle as a clearing write wins.
            if (pend_set_s) begin
               pending_r <= 1'b1;
            end else if ((state_r == ST_INT) && auto_s) begin
               pending_r <= 1'b0;
            end else if (wr_ctrl_s || wr_preset_s) begin
               pending_r <= 1'b0;
            end else begin
               pending_r <= pending_r;
            end
         end
      end

      assign ctrl_q_s[k]   = ctrl_r;
      assign preset_q_s[k] = preset_r;
      assign count_q_s[k]  = count_r;
      assign irq[k]        = irq_r;
   end

endmodule

// File: tb/tb_sb_timer.sv
// Self-checking bench for sb_timer: per-cycle expectations go into queues
// with the stimulus and are popped as each bus cycle completes.
`timescale 1ns/1ps
module tb_sb_timer;
   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] irq;

   sb_timer_if bus ();

   sb_timer #(.NUM_TIMERS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (bus),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] T0_CTRL   = 32'h0000_7F00;
   localparam logic [31:0] T0_PRESET = 32'h0000_7F04;
   localparam logic [31:0] T0_COUNT  = 32'h0000_7F08;
   localparam logic [31:0] T0_HOLE   = 32'h0000_7F0C;
   localparam logic [31:0] T1_CTRL   = 32'h0000_7F10;
   localparam logic [31:0] T1_PRESET = 32'h0000_7F14;
   localparam logic [31:0] T1_COUNT  = 32'h0000_7F18;
   localparam logic [31:0] T1_HOLE   = 32'h0000_7F1C;

   int          check_cnt = 0;
   int          pass_cnt  = 0;
   logic [31:0] exp_q [$];
   string       tag_q [$];
   logic [1:0]  irq_q [$];
   logic        exc_q [$];
   logic [31:0] got_data;
   logic        got_exc;
   logic [1:0]  got_irq;

   // One bus cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
   task automatic bus_cycle(input logic re, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
      bus.sb_ReadEnable  = re;
      bus.sb_WriteEnable = we;
      bus.sb_Address     = addr;
      bus.sb_DataIn      = wdata;
      @(negedge clk);
      got_data = bus.sb_DataOut;
      got_exc  = bus.sb_exception;
      got_irq  = irq;
      @(posedge clk);
      #1;
      bus.sb_ReadEnable  = 1'b0;
      bus.sb_WriteEnable = 1'b0;
      bus.sb_Address     = 32'd0;
      bus.sb_DataIn      = 32'd0;
   endtask

   task automatic test_reset();
      logic [31:0] addrs [6];
      logic [31:0] e;
      logic [1:0]  ei;
      string       t;
      addrs = '{T0_CTRL, T0_PRESET, T0_COUNT, T1_CTRL, T1_PRESET, T1_COUNT};
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(32'd0); tag_q.push_back("reset_read"); irq_q.push_back(2'b00);
      end
      for (int i = 0; i < 6; i++) begin
         bus_cycle(1'b1, 1'b0, addrs[i], 32'd0);
         e = exp_q.pop_front(); t = tag_q.pop_front(); ei = irq_q.pop_front();
         check_cnt++;
         if (got_data !== e) $display("FAIL %s addr=%h got=%h exp=%h", t, addrs[i], got_data, e);
         else pass_cnt++;
         check_cnt++;
         if (got_irq !== ei) $display("FAIL %s_irq got=%b exp=%b", t, got_irq, ei);
         else pass_cnt++;
      end
      // Start a count, then pull reset between clock edges.
      bus_cycle(1'b1, 1'b1, T0_PRESET, 32'd20);
      bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h9);
      repeat (8) bus_cycle(1'b0, 1'b0, 32'd0, 32'd0);
      exp_q.push_back(32'd14); tag_q.push_back("pre_reset_count");
      exp_q.push_back(32'd0);  tag_q.push_back("async_reset_count");
      bus.sb_ReadEnable = 1'b1;
      bus.sb_Address    = T0_COUNT;
      #1;
      e = exp_q.pop_front(); t = tag_q.pop_front();
      check_cnt++;
      if (bus.sb_DataOut !== e) $display("FAIL %s got=%0d exp=%0d", t, bus.sb_DataOut, e);
      else pass_cnt++;
      #1 reset = 1'b0;
      #1;
      e = exp_q.pop_front(); t = tag_q.pop_front();
      check_cnt++;
      if (bus.sb_DataOut !== e) $display("FAIL %s got=%0d exp=%0d", t, bus.sb_DataOut, e);
      else pass_cnt++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.sb_ReadEnable = 1'b0;
      bus.sb_Address    = 32'd0;
      // After release nothing runs, so the count stays 0 and irq never rises.
      for (int c = 0; c < 30; c++) begin
         exp_q.push_back(32'd0); tag_q.push_back("post_reset_count"); irq_q.push_back(2'b00);
      end
      for (int c = 0; c < 30; c++) begin
         bus_cycle(1'b1, 1'b0, T0_COUNT, 32'd0);
         e = exp_q.pop_front(); t = tag_q.pop_front(); ei = irq_q.pop_front();
         check_cnt++;
         if (got_data !== e) $display("FAIL %s c=%0d got=%0d exp=%0d", t, c, got_data, e);
         else pass_cnt++;
         check_cnt++;
         if (got_irq !== ei) $display("FAIL %s_irq c=%0d got=%b exp=%b", t, c, got_irq, ei);
         else pass_cnt++;
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] e;
      logic [1:0]  ei;
      string       t;
      bus_cycle(1'b1, 1'b1, T0_PRESET, 32'd5);
      bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h9);              // cycle 0
      for (int c = 1; c <= 10; c++) begin
         if (c >= 3 && c <= 7) exp_q.push_back(32'(5 - (c - 3)));
         else exp_q.push_back(32'd0);
         tag_q.push_back("oneshot_count");
         irq_q.push_back((c >= 9) ? 2'b01 : 2'b00);
      end
      for (int c = 1; c <= 10; c++) begin
         bus_cycle(1'b1, 1'b0, T0_COUNT, 32'd0);
         e = exp_q.pop_front(); t = tag_q.pop_front(); ei = irq_q.pop_front();
         check_cnt++;
         if (got_data !== e) $display("FAIL %s c=%0d got=%0d exp=%0d", t, c, got_data, e);
         else pass_cnt++;
         check_cnt++;
         if (got_irq !== ei) $display("FAIL %s_irq c=%0d got=%b exp=%b", t, c, got_irq, ei);
         else pass_cnt++;
      end
      exp_q.push_back(32'h8); tag_q.push_back("oneshot_ctrl_en_cleared"); irq_q.push_back(2'b01);
      bus_cycle(1'b1, 1'b0, T0_CTRL, 32'd0);              // cycle 11
      e = exp_q.pop_front(); t = tag_q.pop_front(); ei = irq_q.pop_front();
      check_cnt++;
      if (got_data !== e) $display("FAIL %s got=%h exp=%h", t, got_data, e);
      else pass_cnt++;
      check_cnt++;
      if (got_irq !== ei) $display("FAIL %s_irq got=%b exp=%b", t, got_irq, ei);
      else pass_cnt++;
      bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h8);              // cycle 12: clear pending
      bus_cycle(1'b0, 1'b0, 32'd0, 32'd0);                // cycle 13
      for (int c = 14; c <= 16; c++) begin
         irq_q.push_back(2'b00); tag_q.push_back("oneshot_irq_cleared");
      end
      for (int c = 14; c <= 16; c++) begin
         bus_cycle(1'b0, 1'b0, 32'd0, 32'd0);
         t = tag_q.pop_front(); ei = irq_q.pop_front();
         check_cnt++;
         if (got_irq !== ei) $display("FAIL %s c=%0d got=%b exp=%b", t, c, got_irq, ei);
         else pass_cnt++;
      end
   endtask

   task automatic test_autoreload();
      logic [1:0] ei;
      string      t;
      bus_cycle(1'b1, 1'b1, T1_PRESET, 32'd3);
      bus_cycle(1'b1, 1'b1, T1_CTRL, 32'hB);              // cycle 0
      // Period 5 (irq at 7,12,17,22), then period 3 after PRESET=1 at cycle 18.
      for (int c = 1; c <= 35; c++) begin
         if (c == 7 || c == 12 || c == 17 || c == 22 || c == 25 || c == 28 || c == 31 || c == 34)
            irq_q.push_back(2'b10);
         else
            irq_q.push_back(2'b00);
         tag_q.push_back("autoreload_irq");
      end
      for (int c = 1; c <= 35; c++) begin
         if (c == 18) bus_cycle(1'b1, 1'b1, T1_PRESET, 32'd1);
         else bus_cycle(1'b0, 1'b0, 32'd0, 32'd0);
         t = tag_q.pop_front(); ei = irq_q.pop_front();
         check_cnt++;
         if (got_irq !== ei) $display("FAIL %s c=%0d got=%b exp=%b", t, c, got_irq, ei);
         else pass_cnt++;
      end
      bus_cycle(1'b1, 1'b1, T1_CTRL, 32'h0);
      repeat (4) bus_cycle(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic test_disable();
      logic [31:0] e;
      logic [1:0]  ei;
      string       t;
      bus_cycle(1'b1, 1'b1, T0_PRESET, 32'd100);
      bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h9);              // cycle 0
      for (int c = 1; c <= 62; c++) begin
         exp_q.push_back((c < 3) ? 32'd0 : 32'(100 - (c - 3)));
         tag_q.push_back("disable_counting");
         irq_q.push_back(2'b00);
      end
      for (int c = 1; c <= 62; c++) begin
         bus_cycle(1'b1, 1'b0, T0_COUNT, 32'd0);
         e = exp_q.pop_front(); t = tag_q.pop_front(); ei = irq_q.pop_front();
         check_cnt++;
         if (got_data !== e) $display("FAIL %s c=%0d got=%0d exp=%0d", t, c, got_data, e);
         else pass_cnt++;
         check_cnt++;
         if (got_irq !== ei) $display("FAIL %s_irq c=%0d got=%b exp=%b", t, c, got_irq, ei);
         else pass_cnt++;
      end
      bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h0);              // cycle 63, COUNT=40
      for (int c = 64; c <= 140; c++) begin
         exp_q.push_back(32'd39); tag_q.push_back("disable_frozen"); irq_q.push_back(2'b00);
      end
      for (int c = 64; c <= 140; c++) begin
         bus_cycle(1'b1, 1'b0, T0_COUNT, 32'd0);
         e = exp_q.pop_front(); t = tag_q.pop_front(); ei = irq_q.pop_front();
         check_cnt++;
         if (got_data !== e) $display("FAIL %s c=%0d got=%0d exp=%0d", t, c, got_data, e);
         else pass_cnt++;
         check_cnt++;
         if (got_irq !== ei) $display("FAIL %s_irq c=%0d got=%b exp=%b", t, c, got_irq, ei);
         else pass_cnt++;
      end
   endtask

   task automatic test_faults();
      logic        re_t [8];
      logic        we_t [8];
      logic [31:0] ad_t [8];
      logic [31:0] e;
      logic        ee;
      string       t;
      re_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      we_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ad_t = '{T0_HOLE, T0_COUNT, T1_HOLE, T0_COUNT, T0_CTRL, T0_PRESET, T0_COUNT, T1_HOLE};
      exp_q.push_back(32'd0);   exc_q.push_back(1'b1); tag_q.push_back("fault_read_hole");
      exp_q.push_back(32'd0);   exc_q.push_back(1'b1); tag_q.push_back("fault_write_count");
      exp_q.push_back(32'd0);   exc_q.push_back(1'b1); tag_q.push_back("fault_write_hole1");
      exp_q.push_back(32'd39);  exc_q.push_back(1'b0); tag_q.push_back("count_unchanged");
      exp_q.push_back(32'd0);   exc_q.push_back(1'b0); tag_q.push_back("read_ctrl_ok");
      exp_q.push_back(32'd100); exc_q.push_back(1'b0); tag_q.push_back("read_preset_ok");
      exp_q.push_back(32'd0);   exc_q.push_back(1'b0); tag_q.push_back("no_select");
      exp_q.push_back(32'd0);   exc_q.push_back(1'b1); tag_q.push_back("fault_read_hole1");
      for (int i = 0; i < 8; i++) begin
         bus_cycle(re_t[i], we_t[i], ad_t[i], 32'h0000_1234);
         e = exp_q.pop_front(); ee = exc_q.pop_front(); t = tag_q.pop_front();
         check_cnt++;
         if (got_data !== e) $display("FAIL %s data got=%h exp=%h", t, got_data, e);
         else pass_cnt++;
         check_cnt++;
         if (got_exc !== ee) $display("FAIL %s exc got=%b exp=%b", t, got_exc, ee);
         else pass_cnt++;
      end
   endtask

   task automatic test_mask_collision();
      logic [31:0] e;
      logic [1:0]  ei;
      string       t;
      // IM=0 one-shot: pending is set at INT (cycle 5) but irq stays low.
      bus_cycle(1'b1, 1'b1, T0_PRESET, 32'd2);
      bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h1);              // cycle 0
      for (int c = 1; c <= 14; c++) begin
         if (c != 9) begin
            exp_q.push_back((c <= 5) ? 32'h1 : ((c <= 8) ? 32'h0 : 32'h8));
            tag_q.push_back("mask_ctrl");
            irq_q.push_back(2'b00);
         end
      end
      for (int c = 1; c <= 14; c++) begin
         if (c == 9) begin
            bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h8);
         end else begin
            bus_cycle(1'b1, 1'b0, T0_CTRL, 32'd0);
            e = exp_q.pop_front(); t = tag_q.pop_front(); ei = irq_q.pop_front();
            check_cnt++;
            if (got_data !== e) $display("FAIL %s c=%0d got=%h exp=%h", t, c, got_data, e);
            else pass_cnt++;
            check_cnt++;
            if (got_irq !== ei) $display("FAIL %s_irq c=%0d got=%b exp=%b", t, c, got_irq, ei);
            else pass_cnt++;
         end
      end
      // Collision: CTRL=0x9 written during the INT cycle (cycle 5) keeps EN=1.
      bus_cycle(1'b1, 1'b1, T0_PRESET, 32'd2);
      bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h9);              // cycle 0
      for (int c = 1; c <= 12; c++) begin
         exp_q.push_back((c <= 10) ? 32'h9 : 32'h8);
         tag_q.push_back("collision_ctrl");
         irq_q.push_back((c == 6 || c >= 11) ? 2'b01 : 2'b00);
      end
      for (int c = 1; c <= 12; c++) begin
         if (c == 5) bus_cycle(1'b1, 1'b1, T0_CTRL, 32'h9);
         else bus_cycle(1'b1, 1'b0, T0_CTRL, 32'd0);
         e = exp_q.pop_front(); t = tag_q.pop_front(); ei = irq_q.pop_front();
         check_cnt++;
         if (got_data !== e) $display("FAIL %s c=%0d got=%h exp=%h", t, c, got_data, e);
         else pass_cnt++;
         check_cnt++;
         if (got_irq !== ei) $display("FAIL %s_irq c=%0d got=%b exp=%b", t, c, got_irq, ei);
         else pass_cnt++;
      end
   endtask

   initial begin
      reset              = 1'b0;
      bus.sb_ReadEnable  = 1'b0;
      bus.sb_WriteEnable = 1'b0;
      bus.sb_Address     = 32'd0;
      bus.sb_DataIn      = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      test_reset();
      test_oneshot();
      test_autoreload();
      test_disable();
      test_faults();
      test_mask_collision();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
